// File: rtl/uart_tx_sched_if.sv
// Request/grant and serial-output bundle for the four-way UART transmit scheduler.
interface uart_tx_sched_if;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic        tx;

  modport master (
    output req,
    output data,
    input  gnt,
    input  busy,
    input  done,
    input  tx
  );

  modport slave (
    input  req,
    input  data,
    output gnt,
    output busy,
    output done,
    output tx
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART TX line among four byte requesters.
// Bit timing comes from an internal per-bit counter clocked by clk_in.
module uart_tx_sched #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input logic             clk_in,
  input logic             reset,
  uart_tx_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state, w_stateNext;
  logic [15:0] r_cnt, w_cntNext;
  logic [2:0]  r_bitIdx, w_bitIdxNext;
  logic [1:0]  r_ptr, w_ptrNext;
  logic [7:0]  r_shift, w_shiftNext;
  logic [3:0]  r_gnt, w_gntNext;
  logic        r_tx, w_txNext;
  logic        r_busy, w_busyNext;
  logic        r_done, w_doneNext;
  logic [1:0]  w_sel;
  logic        w_found;
  logic        w_bitEnd;

  assign w_bitEnd = (r_cnt == LP_LAST);

  // Pick the first asserted requester scanning upward from the priority pointer.
  always_comb begin
    w_sel   = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && bus.req[r_ptr + 2'(k)]) begin
        w_sel   = r_ptr + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  // Frame sequencing: grant and capture in IDLE, then start, eight data bits and stop.
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt + 16'd1;
    w_bitIdxNext = r_bitIdx;
    w_ptrNext    = r_ptr;
    w_shiftNext  = r_shift;
    w_txNext     = r_tx;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
    w_gntNext    = 4'b0000;
    case (r_state)
      IDLE: begin
        w_cntNext = '0;
        if (w_found) begin
          w_stateNext  = START;
          w_shiftNext  = bus.data[{w_sel, 3'b000} +: 8];
          w_gntNext    = 4'b0001 << w_sel;
          w_busyNext   = 1'b1;
          w_txNext     = 1'b0;
          w_bitIdxNext = '0;
          w_ptrNext    = w_sel + 2'd1;
        end
      end
      START: begin
        if (w_bitEnd) begin
          w_stateNext = DATA;
          w_cntNext   = '0;
          w_txNext    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          w_cntNext = '0;
          if (r_bitIdx == 3'd7) begin
            w_stateNext = STOP;
            w_txNext    = 1'b1;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
            w_shiftNext  = r_shift >> 1;
            w_txNext     = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_bitEnd) begin
          w_stateNext = IDLE;
          w_cntNext   = '0;
          w_busyNext  = 1'b0;
          w_doneNext  = 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line high.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_ptr    <= '0;
      r_shift  <= '0;
      r_gnt    <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_bitIdx <= w_bitIdxNext;
      r_ptr    <= w_ptrNext;
      r_shift  <= w_shiftNext;
      r_gnt    <= w_gntNext;
      r_tx     <= w_txNext;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus queues expected frames, monitors
// decode the serial line and compare against them.
module tb_uart_tx_sched;

  localparam int  CPB_A  = 4;
  localparam int  CPB_B  = 2;
  localparam time PERIOD = 10;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] data;
    int         gap;
    bit         abort;
  } frame_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;

  frame_t      expA[$];
  logic [19:0] expB[$];
  int          checksTotal  = 0;
  int          checksPassed = 0;

  uart_tx_sched_if busA();
  uart_tx_sched_if busB();

  uart_tx_sched #(.CLKS_PER_BIT(CPB_A)) dutA (.clk_in(clk_in), .reset(reset), .bus(busA));
  uart_tx_sched #(.CLKS_PER_BIT(CPB_B)) dutB (.clk_in(clk_in), .reset(reset), .bus(busB));

  // Free-running system clock
  always #(PERIOD / 2) clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic timeoutFail(input string name);
    checksTotal++;
    $display("[TB] FAIL %s: timed out waiting", name);
  endtask

  task automatic applyStimulus(input bit useB, input logic [3:0] req, input logic [31:0] data);
    if (useB) begin
      busB.data = data;
      busB.req  = req;
    end else begin
      busA.data = data;
      busA.req  = req;
    end
  endtask

  task automatic pushA(input logic [3:0] gnt, input logic [7:0] data, input int gap, input bit abort);
    frame_t e;
    e.gnt   = gnt;
    e.data  = data;
    e.gap   = gap;
    e.abort = abort;
    expA.push_back(e);
  endtask

  task automatic waitGnt(input bit useB, input int maxCycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk_in);
      seen = useB ? (busB.gnt != 4'b0) : (busA.gnt != 4'b0);
    end
    if (!seen) timeoutFail(useB ? "grant B" : "grant A");
  endtask

  task automatic waitDone(input bit useB, input int maxCycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk_in);
      seen = useB ? busB.done : busA.done;
    end
    if (!seen) timeoutFail(useB ? "done B" : "done A");
  endtask

  // Monitor A: on each grant, pop the expected frame and decode the line mid-bit
  initial begin : monitorA
    frame_t     e;
    time        lastGnt;
    logic [7:0] rx;
    logic       stopBit;
    bit         aborted;
    bit         earlyDone;
    int         gap;
    lastGnt = 0;
    forever begin
      @(negedge clk_in);
      if (reset && busA.gnt != 4'b0) begin
        gap     = int'(($time - lastGnt) / PERIOD);
        lastGnt = $time;
        if (expA.size() == 0) begin
          checkOutput("unexpected grant A", 32'(busA.gnt), 32'h0);
        end else begin
          e = expA.pop_front();
          checkOutput("grant A", 32'(busA.gnt), 32'(e.gnt));
          if (e.gap != 0) checkOutput("grant spacing A", gap, e.gap);
          checkOutput("start bit A", 32'(busA.tx), 32'h0);
          rx        = '0;
          stopBit   = 1'b0;
          aborted   = 1'b0;
          earlyDone = 1'b0;
          for (int n = 1; n <= 10 * CPB_A; n++) begin
            @(negedge clk_in);
            if (!reset) begin
              aborted = 1'b1;
              break;
            end
            if (n < 10 * CPB_A && busA.done) earlyDone = 1'b1;
            if (n > CPB_A && n < 9 * CPB_A && (n % CPB_A) == CPB_A / 2)
              rx[3'(n / CPB_A - 1)] = busA.tx;
            if (n == 9 * CPB_A + CPB_A / 2) stopBit = busA.tx;
          end
          checkOutput("frame aborted A", 32'(aborted), 32'(e.abort));
          if (!aborted) begin
            checkOutput("byte A", 32'(rx), 32'(e.data));
            checkOutput("stop bit A", 32'(stopBit), 32'h1);
            checkOutput("early done A", 32'(earlyDone), 32'h0);
            checkOutput("done/busy at frame end A", 32'({busA.done, busA.busy}), 32'h2);
          end
        end
      end
    end
  end

  // Monitor B: capture the raw line cycle by cycle for 20 cycles after a grant
  initial begin : monitorB
    logic [19:0] seen;
    logic [19:0] e;
    forever begin
      @(negedge clk_in);
      if (reset && busB.gnt != 4'b0) begin
        seen     = '0;
        seen[19] = busB.tx;
        for (int n = 1; n < 20; n++) begin
          @(negedge clk_in);
          seen[19 - n] = busB.tx;
        end
        @(negedge clk_in);
        if (expB.size() == 0) begin
          checkOutput("unexpected frame B", 32'(seen), 32'h0);
        end else begin
          e = expB.pop_front();
          checkOutput("tx pattern B", 32'(seen), 32'(e));
          checkOutput("done at cycle 20 B", 32'(busB.done), 32'h1);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin : stimulus
    bit sawDone;
    applyStimulus(1'b0, 4'b0, 32'h0);
    applyStimulus(1'b1, 4'b0, 32'h0);
    repeat (3) @(negedge clk_in);
    checkOutput("reset state A", 32'({busA.tx, busA.busy, busA.done, busA.gnt}), 32'h40);
    checkOutput("reset state B", 32'({busB.tx, busB.busy, busB.done, busB.gnt}), 32'h40);
    reset = 1'b1;
    @(negedge clk_in);

    // Single frame, byte 0x55 from requester 1
    $display("[TB] single frame 0x55");
    pushA(4'b0010, 8'h55, 0, 1'b0);
    applyStimulus(1'b0, 4'b0010, 32'h0000_5500);
    waitGnt(1'b0, 10);
    applyStimulus(1'b0, 4'b0000, 32'h0);
    waitDone(1'b0, 100);

    // Short bit period, byte 0x80
    $display("[TB] CLKS_PER_BIT=2 byte 0x80");
    expB.push_back({16'h0000, 4'hF});
    applyStimulus(1'b1, 4'b0001, 32'h0000_0080);
    waitGnt(1'b1, 10);
    applyStimulus(1'b1, 4'b0000, 32'h0);
    waitDone(1'b1, 50);
    repeat (3) @(negedge clk_in);

    // All four requesting back to back after reset
    $display("[TB] four requesters back to back");
    reset = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    pushA(4'b0001, 8'hA0, 0, 1'b0);
    pushA(4'b0010, 8'hA1, 10 * CPB_A + 1, 1'b0);
    pushA(4'b0100, 8'hA2, 10 * CPB_A + 1, 1'b0);
    pushA(4'b1000, 8'hA3, 10 * CPB_A + 1, 1'b0);
    applyStimulus(1'b0, 4'b1111, 32'hA3A2_A1A0);
    for (int i = 0; i < 4; i++) waitGnt(1'b0, 100);
    applyStimulus(1'b0, 4'b0000, 32'h0);
    waitDone(1'b0, 100);

    // Fairness between requesters 0 and 2
    $display("[TB] fairness 0 vs 2");
    pushA(4'b0001, 8'hB0, 0, 1'b0);
    pushA(4'b0100, 8'hB2, 10 * CPB_A + 1, 1'b0);
    pushA(4'b0001, 8'hB0, 10 * CPB_A + 1, 1'b0);
    pushA(4'b0100, 8'hB2, 10 * CPB_A + 1, 1'b0);
    applyStimulus(1'b0, 4'b0101, 32'h00B2_00B0);
    for (int i = 0; i < 4; i++) waitGnt(1'b0, 100);
    applyStimulus(1'b0, 4'b0000, 32'h0);
    waitDone(1'b0, 100);

    // Reset during data bit 3, then a fresh grant on the first IDLE edge
    $display("[TB] reset mid-frame");
    pushA(4'b0001, 8'h3C, 0, 1'b1);
    applyStimulus(1'b0, 4'b0001, 32'h0000_003C);
    waitGnt(1'b0, 10);
    applyStimulus(1'b0, 4'b0000, 32'h0);
    repeat (17) @(negedge clk_in);
    reset = 1'b0;
    #1;
    checkOutput("tx/busy on reset", 32'({busA.tx, busA.busy}), 32'h2);
    pushA(4'b1000, 8'h5A, 0, 1'b0);
    applyStimulus(1'b0, 4'b1000, 32'h5A00_0000);
    sawDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      if (busA.done) sawDone = 1'b1;
    end
    checkOutput("no done after abort", 32'(sawDone), 32'h0);
    reset = 1'b1;
    @(negedge clk_in);
    checkOutput("first IDLE grant", 32'(busA.gnt), 32'h8);
    applyStimulus(1'b0, 4'b0000, 32'h0);
    waitDone(1'b0, 100);

    // Withdrawn request from requester 1 is never granted
    $display("[TB] withdrawal");
    pushA(4'b0001, 8'h96, 0, 1'b0);
    pushA(4'b0001, 8'h96, 10 * CPB_A + 1, 1'b0);
    applyStimulus(1'b0, 4'b0001, 32'h0000_0096);
    waitGnt(1'b0, 10);
    repeat (15) @(negedge clk_in);
    applyStimulus(1'b0, 4'b0011, 32'h0000_FF96);
    repeat (10) @(negedge clk_in);
    applyStimulus(1'b0, 4'b0001, 32'h0000_0096);
    waitGnt(1'b0, 100);
    applyStimulus(1'b0, 4'b0000, 32'h0);
    waitDone(1'b0, 100);

    repeat (5) @(negedge clk_in);
    checkOutput("scoreboard A drained", 32'(expA.size()), 32'h0);
    checkOutput("scoreboard B drained", 32'(expB.size()), 32'h0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one 8N1 UART transmit line among four requesters. It grants one byte per frame, generates its own bit timing from `clk_in`, and serializes the granted byte LSB first. It sits between the counter/status producers and the board TX pin, and replaces the free-running 9600 Hz divider clock with an internal per-frame bit counter.

## Interface
- `CLKS_PER_BIT`, default 5208, `clk_in` cycles per UART bit (50 MHz / 9600 baud). Legal range 2..65535.
- `clk_in`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low.
- `req`  input  4  request per requester; `req[i]` high means byte `i` is ready.
- `data`  input  32  packed bytes; requester `i` drives `data[8*i+7:8*i]`.
- `gnt`  output  4  one-hot, one-cycle pulse; the byte of requester `i` has been captured.
- `busy`  output  1  a frame is in progress.
- `done`  output  1  one-cycle pulse at frame end.
- `tx`  output  1  serial line, idle high.

## Operation
- Reset (async, `reset`=0):
  - `tx`=1, `busy`=0, `gnt`=0, `done`=0.
  - State IDLE, bit counter 0, bit index 0, priority pointer `ptr`=0.
  - A frame in flight is aborted. Its byte is lost, and no `done` follows.
- States: IDLE, START, DATA, STOP.
- IDLE to START, on any edge with `req`≠0:
  - Select the first asserted requester scanning `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
  - Capture its byte into the shift register.
  - Set `gnt[sel]`=1, `busy`=1, `tx`=0. Counter and bit index go to 0.
  - Set `ptr` = `sel`+1 mod 4.
- START: hold `tx`=0 for CLKS_PER_BIT cycles, then go to DATA and drive bit 0.
- DATA: drive one bit per CLKS_PER_BIT cycles, LSB first. After bit 7's period, go to STOP with `tx`=1.
- STOP: hold `tx`=1 for CLKS_PER_BIT cycles. Then go to IDLE with `busy`=0 and `done`=1 for one cycle.
- `gnt` clears on the edge after it is set. No further grant is issued until IDLE.
- Requester obligations:
  - Hold `req[i]` and its byte stable until `gnt[i]`.
  - `req` is sampled only in IDLE. Data changes after the grant have no effect.
  - Dropping `req[i]` before the grant withdraws the request. It is never granted and there is no error.
- Bit counter is 16 bits, counts 0..CLKS_PER_BIT-1, and wraps to 0 at each bit boundary.

## Timing
- Edge E0 (IDLE, `req` sampled nonzero): `gnt`, `busy`=1 and `tx`=0 all change at E0.
- `tx` bit boundaries: E0 + k·CLKS_PER_BIT, for k=1..9 (k=1: data bit 0; k=9: stop bit).
- Frame end at E0 + 10·CLKS_PER_BIT: `busy`=0 and `done`=1 for exactly one cycle.
- Back-to-back frames:
  - Requests are sampled in the IDLE cycle that carries `done`.
  - The next grant edge is E0 + 10·CLKS_PER_BIT + 1.
  - The stop bit therefore lasts CLKS_PER_BIT+1 cycles. This is intended.
- Grant latency: 1 edge from `req` seen in IDLE. Maximum wait for a continuously requesting source is 3 frames.
- `done` and `gnt` never assert in the same cycle.

## Test plan
- Single frame, CLKS_PER_BIT=4, `req`=4'b0010, byte1=8'h55:
  - `gnt`=4'b0010 for 1 cycle.
  - `tx`=0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - `done` 40 cycles after the grant.
- After reset, `req`=4'b1111 held, bytes A0/A1/A2/A3:
  - Grants in order 0,1,2,3.
  - Decoded bytes A0,A1,A2,A3.
  - Three intermediate stop bits of 5 cycles each (CLKS_PER_BIT=4).
- Fairness: `req[0]` and `req[2]` held high for 4 frames -> grant order 0,2,0,2.
- Reset low during data bit 3:
  - `tx`=1 and `busy`=0 immediately, with no `done`.
  - After release with `req`=4'b1000: `gnt`=4'b1000 on the first IDLE edge.
- Withdrawal: `req[1]` pulsed high for 10 cycles mid-frame while `req[0]` is held -> `gnt[1]` never asserts; only requester 0 is granted.
- CLKS_PER_BIT=2, byte 8'h80 -> `tx` low for 16 cycles (start bit plus bits 0..6), high 2 cycles (bit 7), stop high 2 cycles, `done` at cycle 20.
